// File: rtl/cpu_pkg.sv
// Shared lane and mode encodings for the CPU fan-out blocks.
package cpu_pkg;

  typedef enum logic [1:0] {
    LANE_A = 2'b00,
    LANE_B = 2'b01,
    LANE_C = 2'b10,
    LANE_D = 2'b11
  } lane_e;

  typedef enum logic {
    MODE_RR  = 1'b0,
    MODE_DIR = 1'b1
  } mode_e;

endpackage

// File: rtl/rr_dispatch4_lane_buf.sv
// Single-entry holding register with valid/ready; a load while draining keeps valid high.
module lane_buf #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             free
);

  assign free = ~valid | ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/rr_dispatch4.sv
// One-to-four word distributor: round-robin or directed lane choice, one buffer per lane.
module rr_dispatch4
  import cpu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             mode,
  input  logic [1:0]       dest,
  output logic [1:0]       select,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic             a_valid,
  output logic             b_valid,
  output logic             c_valid,
  output logic             d_valid,
  input  logic             a_ready,
  input  logic             b_ready,
  input  logic             c_ready,
  input  logic             d_ready,
  output logic [CNT_W-1:0] accepted
);

  logic [1:0]       ptr;
  logic             accept;
  logic [3:0]       rdy;
  logic [3:0]       vld;
  logic [3:0]       free;
  logic [3:0]       load;
  logic [WIDTH-1:0] dat [4];

  assign rdy = {d_ready, c_ready, b_ready, a_ready};

  // din_valid deliberately stays out of select/din_ready so no handshake loop forms.
  assign select    = (mode == MODE_DIR) ? dest : ptr;
  assign din_ready = free[select];
  assign accept    = din_valid & din_ready;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign load[gi] = accept & (select == 2'(gi));

    lane_buf #(.WIDTH(WIDTH)) u_lane (
      .clk   (clk),
      .reset (reset),
      .load  (load[gi]),
      .din   (din),
      .ready (rdy[gi]),
      .dout  (dat[gi]),
      .valid (vld[gi]),
      .free  (free[gi])
    );
  end

  assign a = dat[0];
  assign b = dat[1];
  assign c = dat[2];
  assign d = dat[3];
  assign a_valid = vld[0];
  assign b_valid = vld[1];
  assign c_valid = vld[2];
  assign d_valid = vld[3];

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr      <= LANE_A;
      accepted <= '0;
    end else if (accept) begin
      accepted <= accepted + CNT_W'(1);
      if (mode == MODE_RR) ptr <= ptr + 2'd1;
    end
  end

endmodule

// File: tb/tb_rr_dispatch4.sv
// Directed bench for rr_dispatch4 with a lane-tagged scoreboard and reference pointer/counter model.
module tb_rr_dispatch4;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] din;
  logic        din_valid;
  logic        din_ready;
  logic        mode;
  logic [1:0]  dest;
  logic [1:0]  select;
  logic [15:0] a, b, c, d;
  logic        a_valid, b_valid, c_valid, d_valid;
  logic        a_ready, b_ready, c_ready, d_ready;
  logic [7:0]  accepted;

  rr_dispatch4 #(.WIDTH(16), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .mode(mode), .dest(dest), .select(select),
    .a(a), .b(b), .c(c), .d(d),
    .a_valid(a_valid), .b_valid(b_valid), .c_valid(c_valid), .d_valid(d_valid),
    .a_ready(a_ready), .b_ready(b_ready), .c_ready(c_ready), .d_ready(d_ready),
    .accepted(accepted)
  );

  always #5 clk = ~clk;

  logic [15:0] lane_dat [4];
  logic [3:0]  lane_vld;
  assign lane_dat[0] = a;
  assign lane_dat[1] = b;
  assign lane_dat[2] = c;
  assign lane_dat[3] = d;
  assign lane_vld = {d_valid, c_valid, b_valid, a_valid};

  typedef struct {
    logic [1:0]  lane;
    logic [15:0] data;
  } sb_t;

  sb_t        sb [$];
  logic [3:0] mvalid;
  logic [1:0] mptr;
  logic [7:0] mcnt;
  int         total_acc;
  int         npass;
  int         ntotal;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // Entered 1 time unit after a rising edge; leaves 1 time unit after the next one.
  task automatic step(input logic v, input logic [15:0] w, input logic m,
                      input logic [1:0] ds, input logic [3:0] rdy);
    logic [1:0] esel;
    logic       efree;
    logic       found;
    din = w; din_valid = v; mode = m; dest = ds;
    a_ready = rdy[0]; b_ready = rdy[1]; c_ready = rdy[2]; d_ready = rdy[3];
    #1;
    esel  = m ? ds : mptr;
    efree = !mvalid[esel] || rdy[esel];
    chk("select", 32'(select), 32'(esel));
    chk("din_ready", 32'(din_ready), 32'(efree));
    chk("accepted", 32'(accepted), 32'(mcnt));
    for (int l = 0; l < 4; l++) begin
      chk($sformatf("valid_%0d", l), 32'(lane_vld[l]), 32'(mvalid[l]));
      if (mvalid[l] && rdy[l]) begin
        found = 1'b0;
        for (int k = 0; k < sb.size(); k++) begin
          if (sb[k].lane == 2'(l)) begin
            chk($sformatf("lane_data_%0d", l), 32'(lane_dat[l]), 32'(sb[k].data));
            sb.delete(k);
            found = 1'b1;
            break;
          end
        end
        chk($sformatf("sb_hit_%0d", l), 32'(found), 32'd1);
        mvalid[l] = 1'b0;
      end
    end
    if (v && efree) begin
      sb.push_back('{esel, w});
      mvalid[esel] = 1'b1;
      mcnt++;
      total_acc++;
      if (!m) mptr++;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1; din_valid = 1'b0; mode = 1'b0; dest = 2'b00;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
    mvalid = '0; mptr = '0; mcnt = '0;
    sb.delete();
    #1;
    chk("rst_valid", 32'(lane_vld), 32'd0);
    chk("rst_accepted", 32'(accepted), 32'd0);
    chk("rst_select", 32'(select), 32'd0);
    for (int l = 0; l < 4; l++) chk($sformatf("rst_data_%0d", l), 32'(lane_dat[l]), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int cyc;
    npass = 0; ntotal = 0; total_acc = 0;
    din = '0; din_valid = 0; mode = 0; dest = 0;
    a_ready = 0; b_ready = 0; c_ready = 0; d_ready = 0;
    reset = 1'b1;
    mvalid = '0; mptr = '0; mcnt = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset mid-traffic with lane b holding a word
    step(1, 16'h1111, 0, 2'b00, 4'b1111);
    step(1, 16'h2222, 0, 2'b00, 4'b1101);
    step(0, 16'h0000, 0, 2'b00, 4'b0000);
    chk("b_valid_before_rst", 32'(b_valid), 32'd1);
    do_reset(2);

    // Round-robin order, back-to-back
    step(1, 16'h0011, 0, 2'b00, 4'b1111);
    step(1, 16'h0022, 0, 2'b00, 4'b1111);
    step(1, 16'h0033, 0, 2'b00, 4'b1111);
    step(1, 16'h0044, 0, 2'b00, 4'b1111);
    step(1, 16'h0055, 0, 2'b00, 4'b1111);
    step(0, 16'h0000, 0, 2'b00, 4'b1111);
    chk("accepted_5", 32'(accepted), 32'd5);
    chk("drained", 32'(lane_vld), 32'd0);

    // Stall without skip: pointer at d, d full and not draining
    step(1, 16'h0101, 0, 2'b00, 4'b0111);   // b
    step(1, 16'h0202, 0, 2'b00, 4'b0111);   // c
    step(1, 16'h00DD, 0, 2'b00, 4'b0111);   // d, held
    step(1, 16'h0303, 0, 2'b00, 4'b0111);   // a
    step(1, 16'h0404, 0, 2'b00, 4'b0111);   // b
    step(1, 16'h0505, 0, 2'b00, 4'b0111);   // c
    step(1, 16'h0606, 0, 2'b00, 4'b0111);   // stalled
    step(1, 16'h0606, 0, 2'b00, 4'b0111);   // stalled
    chk("stall_select", 32'(select), 32'd3);
    chk("stall_ready", 32'(din_ready), 32'd0);
    step(1, 16'h0606, 0, 2'b00, 4'b1111);   // drain 0x00DD and load
    chk("d_valid_kept", 32'(d_valid), 32'd1);
    chk("d_new_word", 32'(d), 32'h0606);
    step(0, 16'h0000, 0, 2'b00, 4'b1111);

    // Directed mode leaves the pointer alone
    step(1, 16'hBEEF, 1, 2'b10, 4'b0000);
    chk("dir_c", 32'(c), 32'hBEEF);
    chk("dir_c_valid", 32'(c_valid), 32'd1);
    step(1, 16'h0707, 0, 2'b00, 4'b1111);   // resumes at prior pointer (a)
    step(0, 16'h0000, 0, 2'b00, 4'b1111);

    // Ready on an empty lane has no effect
    step(0, 16'h0000, 0, 2'b00, 4'b0010);
    chk("idle_b_ready", 32'(din_ready), 32'd1);
    chk("idle_no_valid", 32'(lane_vld), 32'd0);

    // Counter wrap after 256 accepts with mixed modes and back-pressure
    do_reset(1);
    begin
      int start;
      start = total_acc;
      cyc = 0;
      while (total_acc - start < 256 && cyc < 3000) begin
        step(($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom_range(0, 1)),
             2'($urandom_range(0, 3)), 4'($urandom));
        cyc++;
      end
      chk("wrap_budget", 32'(cyc < 3000), 32'd1);
    end
    #1;
    chk("accepted_wrap", 32'(accepted), 32'd0);
    repeat (3) step(0, 16'h0000, 0, 2'b00, 4'b1111);
    chk("final_empty", 32'(lane_vld), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/rr_dispatch4.md
Name: rr_dispatch4

Overview:
- Sequential distributor that takes a single stream of words and sends each word to one of four output lanes a/b/c/d.
- Lane choice is either strict round-robin or given per word by a destination field.
- Each lane has a one-entry holding register with a valid/ready handshake, so a stalled lane does not lose data.
- Sits where the CPU fans one producer out to four consumers. It adds the sequencing and buffering that a plain 1-to-4 demux lacks.

Parameters:
- WIDTH, 16, data width of din and of each lane output.
- CNT_W, 8, width of the accepted-word counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- din  in  WIDTH  input data word.
- din_valid  in  1  producer has a word on din.
- din_ready  out  1  block accepts din this cycle.
- mode  in  1  0 = round-robin, 1 = directed.
- dest  in  2  target lane when mode=1 (00=a, 01=b, 10=c, 11=d).
- select  out  2  lane targeted this cycle (combinational).
- a, b, c, d  out  WIDTH each  lane data (holding-register contents).
- a_valid, b_valid, c_valid, d_valid  out  1 each  lane holds an undelivered word.
- a_ready, b_ready, c_ready, d_ready  in  1 each  lane consumer takes the word this cycle.
- accepted  out  CNT_W  number of words accepted since reset.

Behaviour:
- Reset (synchronous, active-high) is sampled on the rising edge of clk. It sets:
  - rr pointer = 00
  - all x_valid = 0
  - all lane data = 0
  - accepted = 0
- Reset takes priority over every other event in the same cycle.
- Reset mid-operation discards buffered words with no delivery.
- Target lane:
  - select = rr pointer when mode=0; select = dest when mode=1.
  - select is purely combinational; a mode or dest change takes effect in the same cycle.
- Lane free condition: lane L is free when L_valid=0, or when L_valid=1 and L_ready=1 (drained this cycle).
- Input handshake:
  - din_ready = lane[select] is free. It never depends on din_valid.
  - accept = din_valid & din_ready.
- On accept:
  - lane[select] data <= din and lane[select]_valid <= 1, visible the next cycle (1-cycle latency).
  - accepted <= accepted + 1, wrapping modulo 2^CNT_W.
- rr pointer:
  - Advances (+1 mod 4, 11 wraps to 00) only on an accept in mode=0.
  - Holds in mode=1 and on any non-accept cycle.
- Lane drain: if L_valid & L_ready and L is not written this cycle, then L_valid <= 0. Lane data holds its last value; it is undefined to consumers while invalid.
- Same-lane drain and write in one cycle: the old word is delivered, the new word is loaded, and L_valid stays 1. Full throughput is one word per cycle per lane.
- Target lane full and not draining: din_ready = 0 and the pointer holds. Round-robin never skips a full lane; ordering is strict a, b, c, d.
- Other lanes drain independently of input stalls.
- A consumer asserting ready while its lane is invalid has no effect.
- Outputs are registered. din_ready and select are combinational from state and inputs, and din_valid does not feed them (no loop).

Decomposition:
- Shared package (cpu_pkg):
  - LANE_A=2'b00, LANE_B=2'b01, LANE_C=2'b10, LANE_D=2'b11
  - MODE_RR=1'b0, MODE_DIR=1'b1
- One natural sub-module, lane_buf: a single-entry WIDTH register with valid, load and ready. It is instantiated four times.
- The top level holds the rr pointer, select logic, 2-to-4 load decode and the counter.

Test Plan:
1. Reset check: assert reset for 2 cycles mid-traffic with lane b valid -> all x_valid=0, lane data 0, accepted=0, select=00 in mode=0.
2. Round-robin order: mode=0, all readies=1, stream din=0x0011,0x0022,0x0033,0x0044,0x0055 back-to-back -> each word appears one cycle later on a, b, c, d, a respectively with a single valid pulse each; accepted=5; select wraps 11->00.
3. Stall, no skip: mode=0, d_ready=0 and d already holding 0x00DD, pointer at 11 -> din_ready=0 and the pointer stays 11. Raise d_ready -> 0x00DD is delivered and the new word loads into d in the same cycle; d_valid stays 1.
4. Directed mode: mode=1, dest=10, din=0xBEEF -> c=0xBEEF with c_valid=1 next cycle. The pointer is unchanged, so returning to mode=0 resumes from the prior pointer.
5. Counter wrap: accept 256 words with CNT_W=8 -> accepted reads 0 after the 256th accept.
6. Ignored ready: b_ready=1 while b_valid=0 and din_valid=0 -> no state change, din_ready=1.
